// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;
   localparam int DEFAULT_MAX_WAIT = 8;
   localparam int DEF_AW = 12;
   localparam int DEF_DW = 32;
   typedef enum logic [0:0] {S_PIPE, S_FORCE} arb_state_e;
   typedef enum logic {OWN_LSU, OWN_DBG} owner_e;
   typedef struct packed {
      logic              we;
      logic [DEF_AW-1:0] addr;
      logic [DEF_DW-1:0] wdata;
      logic [3:0]        be;
   } mem_req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: LSU, debug and memory-side signals of the arbiter; slave = arbiter view.
interface dmem_arbiter_if #(parameter int AW = 12, parameter int DW = 32);
   logic          lsu_req_i, lsu_we_i, lsu_stall_o, lsu_rvalid_o;
   logic [AW-1:0] lsu_addr_i;
   logic [DW-1:0] lsu_wdata_i, lsu_rdata_o;
   logic [3:0]    lsu_be_i;
   logic          dbg_req_i, dbg_we_i, dbg_gnt_o, dbg_rvalid_o;
   logic [AW-1:0] dbg_addr_i;
   logic [DW-1:0] dbg_wdata_i, dbg_rdata_o;
   logic [3:0]    dbg_be_i;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;
   logic [3:0]    mem_be_o;
   modport slave (
      input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i, mem_rdata_i,
      output lsu_stall_o, lsu_rvalid_o, lsu_rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );
   modport master (
      output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i, mem_rdata_i,
      input  lsu_stall_o, lsu_rvalid_o, lsu_rdata_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
   );
endinterface

// File: rtl/dmem_arbiter_rsp_router.sv
// dmem_rsp_router: remembers who issued last cycle's read and steers rvalid to that owner.
module dmem_rsp_router
   import dmem_arb_pkg::*;
#(parameter int DW = 32) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i_lsu_rd,
   input  logic          i_dbg_rd,
   input  logic [DW-1:0] i_rdata,
   output logic          o_lsu_rvalid,
   output logic          o_dbg_rvalid,
   output logic [DW-1:0] o_lsu_rdata,
   output logic [DW-1:0] o_dbg_rdata
);
   logic   r_valid;
   owner_e r_owner;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_owner <= OWN_LSU;
      end else begin
         r_valid <= i_lsu_rd | i_dbg_rd;
         r_owner <= i_dbg_rd ? OWN_DBG : OWN_LSU;
      end
   end
   assign o_lsu_rvalid = r_valid && r_owner == OWN_LSU;
   assign o_dbg_rvalid = r_valid && r_owner == OWN_DBG;
   assign o_lsu_rdata  = i_rdata;
   assign o_dbg_rdata  = i_rdata;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: pipeline-priority data-memory arbiter with starvation-forced debug grants.
// Optional DMEM_ARB_PERF_EN adds saturating conflict / forced-grant counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
   input  logic clk_i,
   input  logic rst_i,
   dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0] perf_conflict_o,
   output logic [15:0] perf_force_o
`endif
);
   arb_state_e    r_state, w_next;
   logic [7:0]    r_wait;
   logic          w_force, w_lsu_gnt, w_dbg_gnt;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   // Grants are masked during reset so every output reads 0 while rst_i is held.
   always_comb begin
      w_force   = r_state == S_FORCE;
      w_lsu_gnt = !rst_i && !w_force && bus.lsu_req_i;
      w_dbg_gnt = !rst_i && bus.dbg_req_i && (w_force || !bus.lsu_req_i);
      w_next    = (w_lsu_gnt && bus.dbg_req_i && r_wait == 8'(MAX_WAIT - 1)) ? S_FORCE : S_PIPE;
      w_addr    = w_dbg_gnt ? bus.dbg_addr_i : w_lsu_gnt ? bus.lsu_addr_i : '0;
      w_wdata   = w_dbg_gnt ? bus.dbg_wdata_i : w_lsu_gnt ? bus.lsu_wdata_i : '0;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_PIPE;
         r_wait  <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (w_dbg_gnt || !bus.dbg_req_i) ? '0 : (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
      end
   end
   assign bus.lsu_stall_o = !rst_i && w_force;
   assign bus.dbg_gnt_o   = w_dbg_gnt;
   assign bus.mem_en_o    = w_lsu_gnt | w_dbg_gnt;
   assign bus.mem_we_o    = w_dbg_gnt ? bus.dbg_we_i : w_lsu_gnt && bus.lsu_we_i;
   assign bus.mem_be_o    = w_dbg_gnt ? bus.dbg_be_i : w_lsu_gnt ? bus.lsu_be_i : 4'h0;
   assign bus.mem_addr_o  = w_addr;
   assign bus.mem_wdata_o = w_wdata;
   dmem_rsp_router #(.DW(DW)) u_rsp (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_lsu_rd     (w_lsu_gnt && !bus.lsu_we_i),
      .i_dbg_rd     (w_dbg_gnt && !bus.dbg_we_i),
      .i_rdata      (bus.mem_rdata_i),
      .o_lsu_rvalid (bus.lsu_rvalid_o),
      .o_dbg_rvalid (bus.dbg_rvalid_o),
      .o_lsu_rdata  (bus.lsu_rdata_o),
      .o_dbg_rdata  (bus.dbg_rdata_o)
   );
`ifdef DMEM_ARB_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_conflict_o <= '0;
         perf_force_o    <= '0;
      end else begin
         if (bus.lsu_req_i && bus.dbg_req_i && perf_conflict_o != 16'hFFFF) perf_conflict_o <= perf_conflict_o + 16'd1;
         if (!w_force && w_next == S_FORCE && perf_force_o != 16'hFFFF) perf_force_o <= perf_force_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus reset and starvation sequences against a word memory model.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   dmem_arbiter_if #(.AW(12), .DW(32)) bus ();
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_conflict, perf_force;
`endif
   dmem_arbiter #(.AW(12), .DW(32), .MAX_WAIT(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_conflict_o (perf_conflict),
      .perf_force_o    (perf_force)
`endif
   );
   logic [31:0] mem [1024] = '{4: 32'hDEADBEEF, 17: 32'h11223344, default: 32'h0};
   logic [31:0] mrd;
   always @(posedge clk or posedge rst) begin
      if (rst) mrd <= '0;
      else if (bus.mem_en_o) begin
         if (!bus.mem_we_o) mrd <= mem[bus.mem_addr_o[11:2]];
         else for (int b = 0; b < 4; b++)
            if (bus.mem_be_o[b]) mem[bus.mem_addr_o[11:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      end
   end
   assign bus.mem_rdata_i = mrd;
   typedef struct {
      logic lreq, lwe; logic [11:0] laddr; logic [31:0] lwd; logic [3:0] lbe;
      logic dreq, dwe; logic [11:0] daddr; logic [31:0] dwd; logic [3:0] dbe;
      logic en, we; logic [11:0] addr; logic [31:0] wd; logic [3:0] be;
      logic gnt, lrv, drv; logic [31:0] rd;
   } vec_t;
   vec_t v[8];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   task automatic idle();
      bus.lsu_req_i = 0; bus.lsu_we_i = 0; bus.lsu_addr_i = '0; bus.lsu_wdata_i = '0; bus.lsu_be_i = '0;
      bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0; bus.dbg_be_i = '0;
   endtask
   task automatic apply(input int i, input vec_t t);
      @(posedge clk); #1;
      bus.lsu_req_i = t.lreq; bus.lsu_we_i = t.lwe; bus.lsu_addr_i = t.laddr; bus.lsu_wdata_i = t.lwd; bus.lsu_be_i = t.lbe;
      bus.dbg_req_i = t.dreq; bus.dbg_we_i = t.dwe; bus.dbg_addr_i = t.daddr; bus.dbg_wdata_i = t.dwd; bus.dbg_be_i = t.dbe;
      #1;
      chk($sformatf("v%0d mem_en", i), bus.mem_en_o, t.en);
      chk($sformatf("v%0d mem_we", i), bus.mem_we_o, t.we);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr_o, t.addr);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata_o, t.wd);
      chk($sformatf("v%0d mem_be", i), bus.mem_be_o, t.be);
      chk($sformatf("v%0d dbg_gnt", i), bus.dbg_gnt_o, t.gnt);
      chk($sformatf("v%0d lsu_stall", i), bus.lsu_stall_o, 0);
      @(posedge clk); #1;
      idle();
      #1;
      chk($sformatf("v%0d lsu_rvalid", i), bus.lsu_rvalid_o, t.lrv);
      chk($sformatf("v%0d dbg_rvalid", i), bus.dbg_rvalid_o, t.drv);
      if (t.lrv) chk($sformatf("v%0d lsu_rdata", i), bus.lsu_rdata_o, t.rd);
      if (t.drv) chk($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata_o, t.rd);
   endtask
   // LSU reads 0x010 every cycle while debug waits to read 0x020; forced grant lands on k==8.
   task automatic starve();
      @(posedge clk); #1;
      bus.lsu_req_i = 1; bus.lsu_we_i = 0; bus.lsu_addr_i = 12'h010; bus.lsu_be_i = 4'hF;
      bus.dbg_req_i = 1; bus.dbg_we_i = 0; bus.dbg_addr_i = 12'h020; bus.dbg_be_i = 4'hF;
      for (int k = 0; k <= 8; k++) begin
         #1;
         chk($sformatf("starve%0d dbg_gnt", k), bus.dbg_gnt_o, k == 8);
         chk($sformatf("starve%0d lsu_stall", k), bus.lsu_stall_o, k == 8);
         chk($sformatf("starve%0d mem_addr", k), bus.mem_addr_o, (k == 8) ? 12'h020 : 12'h010);
         if (k > 0) begin
            chk($sformatf("starve%0d lsu_rvalid", k), bus.lsu_rvalid_o, 1);
            chk($sformatf("starve%0d lsu_rdata", k), bus.lsu_rdata_o, 32'hDEADBEEF);
            chk($sformatf("starve%0d dbg_rvalid", k), bus.dbg_rvalid_o, 0);
         end
         @(posedge clk); #1;
         if (k == 8) bus.dbg_req_i = 0;
      end
      #1;
      chk("after_force dbg_gnt", bus.dbg_gnt_o, 0);
      chk("after_force lsu_stall", bus.lsu_stall_o, 0);
      chk("after_force mem_en", bus.mem_en_o, 1);
      chk("after_force mem_addr", bus.mem_addr_o, 12'h010);
      chk("after_force dbg_rvalid", bus.dbg_rvalid_o, 1);
      chk("after_force dbg_rdata", bus.dbg_rdata_o, 32'h12345678);
      chk("after_force lsu_rvalid", bus.lsu_rvalid_o, 0);
      @(posedge clk); #1;
      idle();
      @(posedge clk); #1;
   endtask
   initial begin
      v[0] = '{1,0,12'h010,32'h0,4'hF, 0,0,12'h000,32'h0,4'h0, 1,0,12'h010,32'h0,4'hF, 0,1,0,32'hDEADBEEF};
      v[1] = '{0,0,12'h000,32'h0,4'h0, 1,1,12'h020,32'h12345678,4'hF, 1,1,12'h020,32'h12345678,4'hF, 1,0,0,32'h0};
      v[2] = '{0,0,12'h000,32'h0,4'h0, 1,0,12'h020,32'h0,4'hF, 1,0,12'h020,32'h0,4'hF, 1,0,1,32'h12345678};
      v[3] = '{1,1,12'h030,32'hAAAA5555,4'hF, 1,0,12'h040,32'h0,4'hF, 1,1,12'h030,32'hAAAA5555,4'hF, 0,0,0,32'h0};
      v[4] = '{1,0,12'h030,32'h0,4'hF, 1,1,12'h040,32'hFFFFFFFF,4'h3, 1,0,12'h030,32'h0,4'hF, 0,1,0,32'hAAAA5555};
      v[5] = '{0,0,12'h000,32'h0,4'h0, 0,0,12'h000,32'h0,4'h0, 0,0,12'h000,32'h0,4'h0, 0,0,0,32'h0};
      v[6] = '{1,1,12'h044,32'h0000BEEF,4'h3, 0,0,12'h000,32'h0,4'h0, 1,1,12'h044,32'h0000BEEF,4'h3, 0,0,0,32'h0};
      v[7] = '{1,0,12'h044,32'h0,4'hF, 0,0,12'h000,32'h0,4'h0, 1,0,12'h044,32'h0,4'hF, 0,1,0,32'h1122BEEF};
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset mem_en", bus.mem_en_o, 0);
      chk("reset lsu_rvalid", bus.lsu_rvalid_o, 0);
      chk("reset dbg_rvalid", bus.dbg_rvalid_o, 0);
      rst = 0;
      for (int i = 0; i < 8; i++) apply(i, v[i]);
      // Reset asserted while an LSU read response is in flight.
      @(posedge clk); #1;
      bus.lsu_req_i = 1; bus.lsu_addr_i = 12'h010; bus.lsu_be_i = 4'hF;
      bus.dbg_req_i = 1; bus.dbg_addr_i = 12'h020; bus.dbg_be_i = 4'hF;
      #1;
      chk("midop mem_en", bus.mem_en_o, 1);
      #2 rst = 1;
      #1;
      chk("inrst mem_en", bus.mem_en_o, 0);
      chk("inrst mem_addr", bus.mem_addr_o, 0);
      chk("inrst dbg_gnt", bus.dbg_gnt_o, 0);
      chk("inrst lsu_stall", bus.lsu_stall_o, 0);
      @(posedge clk); #1;
      chk("inrst lsu_rvalid", bus.lsu_rvalid_o, 0);
      chk("inrst lsu_rdata", bus.lsu_rdata_o, 0);
      idle();
      rst = 0;
      @(posedge clk); #1;
      chk("postrst mem_en", bus.mem_en_o, 0);
      chk("postrst lsu_rvalid", bus.lsu_rvalid_o, 0);
      chk("postrst dbg_rvalid", bus.dbg_rvalid_o, 0);
      starve();
      starve();
`ifdef DMEM_ARB_PERF_EN
      chk("perf_force", perf_force, 16'd2);
      chk("perf_conflict", perf_conflict, 16'd18);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
